// File: rtl/kanagawa_fifo_read_prefetch.sv
// kanagawa_fifo_read_prefetch: turns a fixed-latency FIFO read port into a full-throughput valid/ready stream
module kanagawa_fifo_read_prefetch #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic                                  fifo_empty,
  output logic                                  fifo_rdreq,
  input  logic [WIDTH-1:0]                      fifo_q,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      out_data,
  output logic [$clog2(READ_LATENCY+2)-1:0]     occupancy,
  output logic                                  overflow_out
);
  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int OW        = $clog2(BUF_DEPTH + 1);
  localparam int CW        = $clog2(2 * BUF_DEPTH);
  localparam int PW        = $clog2(BUF_DEPTH);

  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic                    valid_q, valid_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]        mem_q [BUF_DEPTH];
  logic [CW-1:0]           inflight_cnt, credits;
  logic                    pop, capture, full, keep;

  // Credit accounting: a read is only issued when a buffer slot is guaranteed for its data
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight_cnt = inflight_cnt + CW'(pipe_q[i]);
    pop        = valid_q && out_ready;
    capture    = pipe_q[READ_LATENCY-1];
    full       = occ_q == OW'(BUF_DEPTH);
    keep       = capture && (!full || pop);
    credits    = CW'(occ_q) + inflight_cnt;
    fifo_rdreq = !rst && !fifo_empty && ((credits - CW'(pop)) < CW'(BUF_DEPTH));
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = fifo_rdreq;
    wr_ptr_d   = keep ? ((wr_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? ((rd_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    occ_d      = occ_q + OW'(keep) - OW'(pop);
    valid_d    = occ_d != '0;
    ovf_d      = ovf_q || (capture && full && !pop);
  end

  // Control state; reset discards in-flight reads and buffered entries
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Buffer storage needs no reset; occupancy decides what is live
  always_ff @(posedge clock) begin
    if (keep) mem_q[wr_ptr_q] <= fifo_q;
  end

  assign out_data     = mem_q[rd_ptr_q];
  assign out_valid    = valid_q;
  assign occupancy    = occ_q;
  assign overflow_out = ovf_q;
endmodule

// File: tb/tb_kanagawa_fifo_read_prefetch.sv
// tb_kanagawa_fifo_read_prefetch: directed checks of the read prefetcher at read latencies 1..4
module tb_kanagawa_fifo_read_prefetch;
  logic        clk, rst;
  logic [3:0]  empty, rdreq, ordy, ovalid, ov;
  logic [31:0] q [4];
  logic [31:0] odata [4];
  logic [2:0]  occ [4];
  logic [31:0] fmem [4][1024];
  int          tail [4];
  int          rx_a [4];
  int          derr_a [4];
  int          viol_a [4];
  int          n_chk, n_err;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 4; g++) begin : u
    localparam int RL = g + 1;
    logic [$clog2(RL+2)-1:0] occ_w;
    logic [31:0] dl [RL];
    int head, rx, derr, viol;
    assign empty[g]  = (head == tail[g]);
    assign q[g]      = dl[RL-1];
    assign occ[g]    = 3'(occ_w);
    assign rx_a[g]   = rx;
    assign derr_a[g] = derr;
    assign viol_a[g] = viol;
    // FIFO model pop side; flushed together with the DUT
    always @(posedge clk or posedge rst) begin
      if (rst) head <= tail[g];
      else if (rdreq[g]) head <= head + 1;
    end
    // Fixed-latency read data path
    always @(posedge clk) begin
      dl[0] <= rdreq[g] ? fmem[g][head % 1024] : 32'hDEADBEEF;
      for (int j = 1; j < RL; j++) dl[j] <= dl[j-1];
    end
    // Scoreboard: every accepted item must be the next pushed one
    always @(negedge clk) begin
      if (rst) rx <= tail[g];
      else begin
        if (rdreq[g] && empty[g]) viol <= viol + 1;
        if (ovalid[g] && ordy[g]) begin
          if (odata[g] !== fmem[g][rx % 1024]) derr <= derr + 1;
          rx <= rx + 1;
        end
      end
    end
    kanagawa_fifo_read_prefetch #(.WIDTH(32), .READ_LATENCY(RL)) dut (
      .clock(clk), .rst(rst), .fifo_empty(empty[g]), .fifo_rdreq(rdreq[g]),
      .fifo_q(q[g]), .out_valid(ovalid[g]), .out_ready(ordy[g]),
      .out_data(odata[g]), .occupancy(occ_w), .overflow_out(ov[g]));
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    fmem[k][tail[k] % 1024] = d;
    tail[k]++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ordy = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic observe(input int k, input int n, output int nrd, output int nv, output int frd,
                         output int lrd, output int fv, output int lv, output logic [31:0] vd);
    nrd = 0; nv = 0; frd = -1; lrd = -1; fv = -1; lv = -1; vd = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rdreq[k]) begin nrd++; if (frd < 0) frd = i; lrd = i; end
      if (ovalid[k]) begin nv++; if (fv < 0) fv = i; lv = i; vd = odata[k]; end
      cyc();
    end
  endtask

  initial begin
    int nrd, nv, frd, lrd, fv, lv, base, done;
    int bs [4];
    int pushed [4];
    logic [31:0] vd;
    clk = 0; rst = 1; ordy = '0; n_chk = 0; n_err = 0;
    for (int k = 0; k < 4; k++) begin tail[k] = 0; pushed[k] = 0; end
    #1;
    chk("rst_valid", ovalid[0], 0);
    chk("rst_occ", occ[0], 0);
    chk("rst_rdreq", rdreq[0], 0);
    chk("rst_ovf", ov[0], 0);
    cyc(); cyc(); cyc();
    rst = 0;
    // single item, latency 1
    ordy[0] = 1;
    push(0, 32'hA5);
    observe(0, 8, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t1_nrd", nrd, 1);
    chk("t1_frd", frd, 0);
    chk("t1_nv", nv, 1);
    chk("t1_first_valid", fv, 2);
    chk("t1_data", vd, 32'hA5);
    chk("t1_occ_end", occ[0], 0);
    // 16 items streaming, latency 2
    do_reset();
    ordy[1] = 1;
    for (int i = 0; i < 16; i++) push(1, i);
    observe(1, 24, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t2_nrd", nrd, 16);
    chk("t2_frd", frd, 0);
    chk("t2_lrd", lrd, 15);
    chk("t2_nv", nv, 16);
    chk("t2_fv", fv, 3);
    chk("t2_lv", lv, 18);
    chk("t2_last", vd, 15);
    // backpressure, latency 3
    do_reset();
    base = tail[2];
    for (int i = 0; i < 10; i++) push(2, 32'h300 + i);
    observe(2, 20, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t3_nrd_held", nrd, 4);
    @(negedge clk);
    chk("t3_occ_full", occ[2], 4);
    chk("t3_valid", ovalid[2], 1);
    cyc();
    ordy[2] = 1;
    observe(2, 40, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t3_nrd_rest", nrd, 6);
    chk("t3_nv", nv, 10);
    chk("t3_delivered", rx_a[2] - base, 10);
    chk("t3_last", vd, 32'h309);
    // FIFO drains with 2 reads in flight, latency 2
    do_reset();
    ordy[1] = 1;
    push(1, 32'h11);
    push(1, 32'h22);
    observe(1, 10, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t6_nrd", nrd, 2);
    chk("t6_nv", nv, 2);
    chk("t6_fv", fv, 3);
    chk("t6_lv", lv, 4);
    chk("t6_last", vd, 32'h22);
    // async reset with 3 in flight and 2 buffered, latency 4
    do_reset();
    for (int i = 0; i < 10; i++) push(3, 32'h400 + i);
    repeat (6) cyc();
    chk("t5_occ_pre", occ[3], 2);
    chk("t5_valid_pre", ovalid[3], 1);
    rst = 1;
    #1;
    chk("t5_valid_rst", ovalid[3], 0);
    chk("t5_occ_rst", occ[3], 0);
    chk("t5_rdreq_rst", rdreq[3], 0);
    cyc(); cyc();
    rst = 0;
    base = tail[3];
    for (int i = 0; i < 3; i++) push(3, 32'h100 + i);
    ordy[3] = 1;
    observe(3, 20, nrd, nv, frd, lrd, fv, lv, vd);
    chk("t5_nv", nv, 3);
    chk("t5_delivered", rx_a[3] - base, 3);
    chk("t5_last", vd, 32'h102);
    // random ready and pushes, latencies 1, 2 and 4
    do_reset();
    for (int k = 0; k < 4; k++) begin bs[k] = tail[k]; pushed[k] = 0; end
    done = 0;
    for (int c = 0; c < 20000 && done == 0; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 2) continue;
        ordy[k] = 1'($urandom_range(0, 1));
        if (pushed[k] < 1000 && $urandom_range(0, 1) == 1) begin
          push(k, $urandom);
          pushed[k]++;
        end
      end
      cyc();
      done = (rx_a[0] - bs[0] >= 1000 && rx_a[1] - bs[1] >= 1000 && rx_a[3] - bs[3] >= 1000) ? 1 : 0;
    end
    chk("rnd_l1_count", rx_a[0] - bs[0], 1000);
    chk("rnd_l2_count", rx_a[1] - bs[1], 1000);
    chk("rnd_l4_count", rx_a[3] - bs[3], 1000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("data_order_%0d", k), derr_a[k], 0);
      chk($sformatf("rd_while_empty_%0d", k), viol_a[k], 0);
      chk($sformatf("overflow_%0d", k), ov[k], 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/kanagawa_fifo_read_prefetch.md
Name: kanagawa_fifo_read_prefetch

Overview:
Downstream consumer stage for the write-delay FIFO. It converts the FIFO's rdreq/q/empty read port, which has a fixed read latency, into a valid/ready stream with full throughput. Reads are issued speculatively into a small credit-tracked output buffer, so the FIFO is never popped while empty and the buffer never overflows. The block sits between the FIFO read side and any stream consumer in the generated pipeline.

Parameters:
WIDTH, 32, data width in bits.
READ_LATENCY, 1, cycles from fifo_rdreq asserted to fifo_q valid; legal range 1..4.
BUF_DEPTH (localparam), READ_LATENCY+1, output buffer entries; the minimum needed for 1 item/cycle.

Ports:
clock  in  1  single clock; all state on posedge.
rst  in  1  reset; asynchronous, active-high.
fifo_empty  in  1  FIFO empty flag; a read is legal only when 0.
fifo_rdreq  out  1  pop request to FIFO.
fifo_q  in  WIDTH  FIFO read data, valid READ_LATENCY cycles after fifo_rdreq.
out_valid  out  1  head of buffer holds data.
out_ready  in  1  consumer accepts when out_valid=1.
out_data  out  WIDTH  head entry.
occupancy  out  clog2(BUF_DEPTH+1)  entries currently in buffer (debug).
overflow_out  out  1  sticky; capture into a full buffer occurred.

Behaviour:
- Reset (async assert): out_valid=0, occupancy=0, overflow_out=0, fifo_rdreq=0, in-flight pipe cleared, buffer pointers=0. out_data is don't-care. Deassertion is used synchronously.
- In-flight tracking: an inflight_pipe[READ_LATENCY-1:0] shift register of valid bits. Bit 0 is loaded with fifo_rdreq each cycle; the top bit marks that fifo_q is valid this cycle.
- inflight_cnt = popcount(inflight_pipe). credits_used = occupancy + inflight_cnt, computed on a clog2(2*BUF_DEPTH) width with no wrap.
- fifo_rdreq = !rst && !fifo_empty && (credits_used - pop < BUF_DEPTH), where pop = out_valid && out_ready. This path is combinational and issues in the same cycle as the empty flag.
- Capture: when the top pipe bit is 1, fifo_q is written at wr_ptr and wr_ptr increments modulo BUF_DEPTH.
- Pop: when out_valid && out_ready, rd_ptr increments modulo BUF_DEPTH. out_data = buf[rd_ptr].
- occupancy_next = occupancy + capture - pop. Capture and pop in the same cycle leave occupancy unchanged.
- A capture while full and not popping sets overflow_out (sticky until rst) and drops the data. The credit rule makes this unreachable; it exists only as a checker.
- out_valid = (occupancy != 0), registered.
- Latency: if fifo_empty falls at cycle t with the buffer empty, fifo_rdreq=1 at t and out_valid=1 at t+READ_LATENCY+1 (one capture edge).
- Throughput: with out_ready held high and the FIFO non-empty, 1 item/cycle sustained indefinitely.
- Backpressure: with out_ready=0, at most BUF_DEPTH reads are outstanding, then fifo_rdreq stays 0.
- fifo_empty rising while reads are in flight: those reads still complete. The FIFO was non-empty when they were issued, so no underflow occurs.
- Reset mid-operation: in-flight reads and buffered data are discarded. The FIFO is reset in the same domain, so no resync is needed.
- Ordering: strictly FIFO. Buffer pointers wrap cleanly at BUF_DEPTH, including non-power-of-2 depths (READ_LATENCY=2 gives depth 3).

Test Plan:
- READ_LATENCY=1, single item 0xA5 pushed upstream, out_ready=1 -> fifo_rdreq pulses once, out_valid high for exactly 1 cycle with out_data=0xA5, then out_valid=0 and fifo_rdreq=0.
- READ_LATENCY=2, 16 items 0..15 in FIFO, out_ready=1 -> fifo_rdreq high 16 consecutive cycles, out_data 0..15 on 16 consecutive cycles, no gaps after first.
- READ_LATENCY=3, 10 items, out_ready=0 for 20 cycles -> exactly 4 fifo_rdreq pulses, occupancy=4, then raise ready -> all 10 items emerge in order.
- Random out_ready (50%) and random upstream pushes, 1000 items, READ_LATENCY in {1,2,4} -> data in order, overflow_out=0, fifo_rdreq never high while fifo_empty=1.
- Async rst asserted mid-stream with 3 in flight and 2 buffered -> out_valid=0 and occupancy=0 the same cycle; after release, no stale data appears.
- FIFO empties while 2 reads in flight (READ_LATENCY=2) -> both items delivered, no further fifo_rdreq, out_valid drops after last pop.
